// File: rtl/snake_pkg.sv
// Shared types and constants for the snake collision controller.
// Seven-segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package snake_pkg;

   typedef enum logic [1:0] {
      UP    = 2'b00,
      LEFT  = 2'b01,
      DOWN  = 2'b10,
      RIGHT = 2'b11
   } dir_t;

   typedef enum logic [1:0] {
      ALIVE = 2'b00,
      GRACE = 2'b01,
      DEAD  = 2'b10
   } coll_state_t;

   localparam logic [6:0] SEG_d     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-cell calculator: steps the head one cell in dir and flags a wall
// crossing, or wraps to the opposite edge when WRAP is set.
module snake_next_head
   import snake_pkg::*;
#(
   parameter int ROWS = 16,
   parameter int COLS = 16,
   parameter int WRAP = 0,
   parameter int XW   = (ROWS > 1) ? $clog2(ROWS) : 1,
   parameter int YW   = (COLS > 1) ? $clog2(COLS) : 1
) (
   input  logic [XW-1:0] head_x,
   input  logic [YW-1:0] head_y,
   input  dir_t          dir,
   output logic [XW-1:0] next_x,
   output logic [YW-1:0] next_y,
   output logic          wall
);

   localparam logic [XW-1:0] X_MAX = XW'(ROWS - 1);
   localparam logic [YW-1:0] Y_MAX = YW'(COLS - 1);

   // On a wall the head is left unchanged so the body lookup stays in range.
   always_comb begin
      next_x = head_x;
      next_y = head_y;
      wall   = 1'b0;
      case (dir)
         UP: begin
            if (head_x == '0) begin
               if (WRAP != 0) next_x = X_MAX;
               else           wall   = 1'b1;
            end else begin
               next_x = head_x - XW'(1);
            end
         end
         LEFT: begin
            if (head_y == Y_MAX) begin
               if (WRAP != 0) next_y = '0;
               else           wall   = 1'b1;
            end else begin
               next_y = head_y + YW'(1);
            end
         end
         DOWN: begin
            if (head_x == X_MAX) begin
               if (WRAP != 0) next_x = '0;
               else           wall   = 1'b1;
            end else begin
               next_x = head_x + XW'(1);
            end
         end
         default: begin
            if (head_y == '0) begin
               if (WRAP != 0) next_y = Y_MAX;
               else           wall   = 1'b1;
            end else begin
               next_y = head_y - YW'(1);
            end
         end
      endcase
   end

endmodule

// File: rtl/snake_collision_ctrl.sv
// Snake collision controller: classifies each tick's next head cell and tracks lives/grace.
// Define SNAKE_COLLIDE_HEX_EN to add the HEX5..HEX2 "dEAd" display outputs.
//
// state | meaning
// ALIVE | normal play, wall and body hits cost a life
// GRACE | after a non-fatal hit; body hits ignored for grace_cnt ticks
// DEAD  | lives exhausted; ticks ignored until restart/reset
module snake_collision_ctrl
   import snake_pkg::*;
#(
   parameter int ROWS        = 16,
   parameter int COLS        = 16,
   parameter int WRAP        = 0,
   parameter int LIVES       = 3,
   parameter int GRACE_TICKS = 4,
   localparam int XW = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int YW = (COLS > 1) ? $clog2(COLS) : 1,
   localparam int LW = $clog2(LIVES + 1)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       restart,
   input  logic                       enable,
   input  logic [XW-1:0]              head_x,
   input  logic [YW-1:0]              head_y,
   input  logic [1:0]                 dir,
   input  logic [ROWS-1:0][COLS-1:0]  body,
   input  logic [XW-1:0]              food_x,
   input  logic [YW-1:0]              food_y,
   output logic [XW-1:0]              next_x,
   output logic [YW-1:0]              next_y,
   output logic                       move_ok,
   output logic                       ate,
   output logic                       hit,
   output logic [LW-1:0]              lives,
   output logic                       died
`ifdef SNAKE_COLLIDE_HEX_EN
   ,
   output logic [6:0]                 HEX5,
   output logic [6:0]                 HEX4,
   output logic [6:0]                 HEX3,
   output logic [6:0]                 HEX2
`endif
);

   localparam int GW = (GRACE_TICKS > 0) ? $clog2(GRACE_TICKS + 1) : 1;
   localparam logic [LW-1:0] LIVES_INIT = LW'(LIVES);
   localparam logic [GW-1:0] GRACE_INIT = GW'(GRACE_TICKS);

   coll_state_t   state, state_d;
   logic [GW-1:0] grace_cnt, grace_d;
   logic [LW-1:0] lives_d;
   logic          died_d;
   logic [XW-1:0] nx_d, nh_x;
   logic [YW-1:0] ny_d, nh_y;
   logic          move_ok_d, ate_d, hit_d;
   logic          wall, body_hit, food_hit;

   snake_next_head #(
      .ROWS (ROWS),
      .COLS (COLS),
      .WRAP (WRAP),
      .XW   (XW),
      .YW   (YW)
   ) u_next_head (
      .head_x (head_x),
      .head_y (head_y),
      .dir    (dir_t'(dir)),
      .next_x (nh_x),
      .next_y (nh_y),
      .wall   (wall)
   );

   assign body_hit = body[nh_x][nh_y];
   assign food_hit = (nh_x == food_x) && (nh_y == food_y);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ALIVE;
         grace_cnt <= '0;
         lives     <= LIVES_INIT;
         died      <= 1'b0;
         next_x    <= '0;
         next_y    <= '0;
         move_ok   <= 1'b0;
         ate       <= 1'b0;
         hit       <= 1'b0;
      end else begin
         state     <= state_d;
         grace_cnt <= grace_d;
         lives     <= lives_d;
         died      <= died_d;
         next_x    <= nx_d;
         next_y    <= ny_d;
         move_ok   <= move_ok_d;
         ate       <= ate_d;
         hit       <= hit_d;
      end
   end

   always_comb begin
      state_d   = state;
      grace_d   = grace_cnt;
      lives_d   = lives;
      died_d    = died;
      nx_d      = next_x;
      ny_d      = next_y;
      move_ok_d = 1'b0;
      ate_d     = 1'b0;
      hit_d     = 1'b0;
      if (restart) begin
         state_d = ALIVE;
         grace_d = '0;
         lives_d = LIVES_INIT;
         died_d  = 1'b0;
         nx_d    = '0;
         ny_d    = '0;
      end else if (enable && (state != DEAD)) begin
         if (wall || (body_hit && (state == ALIVE))) begin
            hit_d = 1'b1;
            if (lives <= LW'(1)) begin
               state_d = DEAD;
               lives_d = '0;
               died_d  = 1'b1;
               grace_d = '0;
            end else begin
               lives_d = lives - LW'(1);
               if (GRACE_TICKS > 0) begin
                  state_d = GRACE;
                  grace_d = GRACE_INIT;
               end else begin
                  state_d = ALIVE;
               end
            end
         end else begin
            move_ok_d = 1'b1;
            nx_d      = nh_x;
            ny_d      = nh_y;
            // An ignored body cell during grace counts as free, never as food.
            ate_d     = food_hit && !body_hit;
            if (state == GRACE) begin
               if (grace_cnt <= GW'(1)) begin
                  state_d = ALIVE;
                  grace_d = '0;
               end else begin
                  grace_d = grace_cnt - GW'(1);
               end
            end
         end
      end
   end

`ifdef SNAKE_COLLIDE_HEX_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         {HEX5, HEX4, HEX3, HEX2} <= {4{SEG_BLANK}};
      end else if (restart || !died) begin
         {HEX5, HEX4, HEX3, HEX2} <= {4{SEG_BLANK}};
      end else begin
         {HEX5, HEX4, HEX3, HEX2} <= {SEG_d, SEG_E, SEG_A, SEG_d};
      end
   end
`endif

endmodule

// File: tb/tb_snake_collision_ctrl.sv
// Directed bench: a 16x16 walled instance and a 12x12 wrapping instance.
module tb_snake_collision_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // 16x16 walled instance
   logic              rst, rs16, en16;
   logic [3:0]        hx16, hy16, fx16, fy16;
   logic [1:0]        dr16;
   logic [15:0][15:0] body16;
   logic [3:0]        nx16, ny16;
   logic              mv16, ate16, hit16, died16;
   logic [1:0]        lv16;
`ifdef SNAKE_COLLIDE_HEX_EN
   logic [6:0]        h5, h4, h3, h2;
`endif

   snake_collision_ctrl dut16 (
      .clk     (clk),
      .reset   (rst),
      .restart (rs16),
      .enable  (en16),
      .head_x  (hx16),
      .head_y  (hy16),
      .dir     (dr16),
      .body    (body16),
      .food_x  (fx16),
      .food_y  (fy16),
      .next_x  (nx16),
      .next_y  (ny16),
      .move_ok (mv16),
      .ate     (ate16),
      .hit     (hit16),
      .lives   (lv16),
      .died    (died16)
`ifdef SNAKE_COLLIDE_HEX_EN
      ,
      .HEX5    (h5),
      .HEX4    (h4),
      .HEX3    (h3),
      .HEX2    (h2)
`endif
   );

   // 12x12 wrapping instance
   logic              rs12, en12;
   logic [3:0]        hx12, hy12, fx12, fy12;
   logic [1:0]        dr12;
   logic [11:0][11:0] body12;
   logic [3:0]        nx12, ny12;
   logic              mv12, ate12, hit12, died12;
   logic [1:0]        lv12;
`ifdef SNAKE_COLLIDE_HEX_EN
   logic [6:0]        g5, g4, g3, g2;
`endif

   snake_collision_ctrl #(.ROWS(12), .COLS(12), .WRAP(1)) dut12 (
      .clk     (clk),
      .reset   (rst),
      .restart (rs12),
      .enable  (en12),
      .head_x  (hx12),
      .head_y  (hy12),
      .dir     (dr12),
      .body    (body12),
      .food_x  (fx12),
      .food_y  (fy12),
      .next_x  (nx12),
      .next_y  (ny12),
      .move_ok (mv12),
      .ate     (ate12),
      .hit     (hit12),
      .lives   (lv12),
      .died    (died12)
`ifdef SNAKE_COLLIDE_HEX_EN
      ,
      .HEX5    (g5),
      .HEX4    (g4),
      .HEX3    (g3),
      .HEX2    (g2)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick16(input logic [3:0] x, input logic [3:0] y, input logic [1:0] d);
      hx16 = x; hy16 = y; dr16 = d; en16 = 1'b1;
      step();
      en16 = 1'b0;
   endtask

   task automatic tick12(input logic [3:0] x, input logic [3:0] y, input logic [1:0] d);
      hx12 = x; hy12 = y; dr12 = d; en12 = 1'b1;
      step();
      en12 = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      rs16 = 1'b0; en16 = 1'b0; hx16 = '0; hy16 = '0; dr16 = '0;
      body16 = '0; fx16 = 4'd14; fy16 = 4'd14;
      rs12 = 1'b0; en12 = 1'b0; hx12 = '0; hy12 = '0; dr12 = '0;
      body12 = '0; fx12 = 4'd10; fy12 = 4'd10;
      step(); step();
      chk("rst_next_x", nx16, 0);
      chk("rst_pulses", {mv16, ate16, hit16}, 0);
      chk("rst_lives", lv16, 3);
      chk("rst_died", died16, 0);
      chk("rst_lives12", lv12, 3);
      rst = 1'b0;
      step();

      // free move
      tick16(4'd5, 4'd5, 2'b11);
      chk("free_next", {nx16, ny16}, {4'd5, 4'd4});
      chk("free_pulse", {mv16, ate16, hit16}, 3'b100);
      chk("free_lives", lv16, 3);
      step();
      chk("free_pulse_end", mv16, 0);

      // food
      fx16 = 4'd6; fy16 = 4'd5;
      tick16(4'd5, 4'd5, 2'b10);
      chk("food_next", {nx16, ny16}, {4'd6, 4'd5});
      chk("food_pulse", {mv16, ate16, hit16}, 3'b110);
      step();
      chk("food_ate_end", ate16, 0);
      fx16 = 4'd14; fy16 = 4'd14;

      // body hit, grace window, body hit again
      body16[9][8] = 1'b1;
      tick16(4'd9, 4'd9, 2'b11);
      chk("body_hit", {mv16, hit16}, 2'b01);
      chk("body_lives", lv16, 2);
      tick16(4'd9, 4'd9, 2'b11);
      chk("grace_ignore", {mv16, hit16}, 2'b10);
      chk("grace_next", {nx16, ny16}, {4'd9, 4'd8});
      for (int i = 0; i < 3; i++) tick16(4'd9, 4'd9, 2'b11);
      chk("grace_last", {mv16, hit16}, 2'b10);
      tick16(4'd9, 4'd9, 2'b11);
      chk("post_grace_hit", {mv16, hit16}, 2'b01);
      chk("post_grace_lives", lv16, 1);
      body16 = '0;

      // restart beats a same-cycle wall tick
      hx16 = 4'd0; hy16 = 4'd5; dr16 = 2'b00; en16 = 1'b1; rs16 = 1'b1;
      step();
      rs16 = 1'b0; en16 = 1'b0;
      chk("restart_hit", hit16, 0);
      chk("restart_lives", lv16, 3);
      chk("restart_next", {nx16, ny16}, 8'h00);

      // reset during grace
      tick16(4'd0, 4'd5, 2'b00);
      chk("pre_rst_lives", lv16, 2);
      rst = 1'b1;
      #2;
      chk("async_rst_lives", lv16, 3);
      rst = 1'b0;
      step();
      body16[9][8] = 1'b1;
      tick16(4'd9, 4'd9, 2'b11);
      chk("rst_alive_hit", hit16, 1);
      body16 = '0;

      // walls to death
      rs16 = 1'b1; step(); rs16 = 1'b0;
      tick16(4'd5, 4'd5, 2'b11);
      tick16(4'd0, 4'd7, 2'b00);
      chk("wall_up", {hit16, lv16}, {1'b1, 2'd2});
      tick16(4'd7, 4'd15, 2'b01);
      chk("wall_left", {hit16, lv16}, {1'b1, 2'd1});
      tick16(4'd15, 4'd7, 2'b10);
      chk("wall_down", {hit16, lv16, died16}, {1'b1, 2'd0, 1'b1});
`ifdef SNAKE_COLLIDE_HEX_EN
      chk("hex_lag", {h5, h4, h3, h2}, {4{7'h7F}});
      step();
      chk("hex_dead", {h5, h4, h3, h2}, {7'h21, 7'h06, 7'h08, 7'h21});
`endif
      tick16(4'd5, 4'd5, 2'b11);
      chk("dead_pulses", {mv16, ate16, hit16}, 0);
      chk("dead_next", {nx16, ny16}, {4'd5, 4'd4});
      chk("dead_state", {lv16, died16}, {2'd0, 1'b1});
      rs16 = 1'b1; step(); rs16 = 1'b0;
      chk("dead_restart", {lv16, died16}, {2'd3, 1'b0});
`ifdef SNAKE_COLLIDE_HEX_EN
      chk("hex_restart", {h5, h4, h3, h2}, {4{7'h7F}});
`endif
      tick16(4'd7, 4'd0, 2'b11);
      chk("wall_right", {hit16, mv16, lv16}, {1'b1, 1'b0, 2'd2});

      // wrap on 12x12
      tick12(4'd0, 4'd3, 2'b00);
      chk("wrap_up", {nx12, ny12, mv12, hit12}, {4'd11, 4'd3, 1'b1, 1'b0});
      tick12(4'd4, 4'd11, 2'b01);
      chk("wrap_left", {nx12, ny12, mv12, hit12}, {4'd4, 4'd0, 1'b1, 1'b0});
      tick12(4'd11, 4'd2, 2'b10);
      chk("wrap_down", {nx12, ny12, mv12}, {4'd0, 4'd2, 1'b1});
      tick12(4'd6, 4'd0, 2'b11);
      chk("wrap_right", {nx12, ny12, mv12}, {4'd6, 4'd11, 1'b1});
      chk("wrap_lives", lv12, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
